uart_baud_tick_ctrl: RTL

- Runtime-programmable baud scheduler for the UART IP. Driven from the divided system clock `clk_in`.
- Produces single-cycle clock-enable pulses instead of derived clocks:
  - `rx_tick` at the oversample rate;
  - `tx_tick` every OVERSAMPLE `rx_tick`s.
- Accepts new divisor values through a valid/ready handshake and applies them glitch-free, only at period boundaries.
- Sits between the register interface and the UART TX/RX engines.

---
 rtl/uart_clk_pkg.sv | 19 +
 rtl/uart_baud_tick_ctrl_tick_counter.sv | 40 ++++
 rtl/uart_baud_tick_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_clk_pkg.sv
// Shared types and constants for the UART baud tick scheduler.
// The default-divisor helper keeps DEFAULT_DIV derivable from the clock frequency.
package uart_clk_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam int MIN_DIV      = 2;
    localparam int DEFAULT_BAUD = 115200;

    // clk_in cycles per oversample tick, truncated toward zero.
    function automatic int calc_default_div(input int base_mhz, input int baud, input int oversample);
        return (base_mhz * 1000000) / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick_ctrl_tick_counter.sv
// Modulo-(last+1) counter with clear, load and a wrap pulse.
// The wrap pulse does not depend on clear, so a terminal count can be observed on the edge that clears.
module tick_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic [WIDTH-1:0] last,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign wrap = en && (count_q == last);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (ld) begin
            count_d = ld_val;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_baud_tick_ctrl.sv
// Runtime-programmable baud scheduler: rx_tick at the oversample rate, tx_tick every OVERSAMPLE rx_ticks.
// New divisors arrive over valid/ready and take effect only at a period boundary (or immediately when stopped).
module uart_baud_tick_ctrl
    import uart_clk_pkg::*;
#(
    parameter int DIV_WIDTH      = 16,
    parameter int OVERSAMPLE     = 16,
    parameter int BASE_FREQUENCY = 100,
    parameter int DEFAULT_DIV    = calc_default_div(BASE_FREQUENCY, DEFAULT_BAUD, OVERSAMPLE)
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 rx_tick,
    output logic                 tx_tick,
    output logic                 locked,
    output logic [DIV_WIDTH-1:0] active_div
);

    localparam int OS_W = $clog2(OVERSAMPLE);

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] pend_q, pend_d;
    logic                 rx_tick_q, rx_tick_d;
    logic                 tx_tick_q, tx_tick_d;
    logic                 locked_q, locked_d;
    logic                 cfg_ready_q, cfg_ready_d;

    logic xfer;
    logic per_en, per_clr, per_wrap;
    logic os_clr, os_wrap;
    logic apply;

    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] v);
        return (v < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : v;
    endfunction

    assign xfer    = cfg_valid && cfg_ready_q;
    assign per_en  = (state_q != STOP) && enable;
    assign per_clr = !per_en;
    assign apply   = (state_q == PEND) && per_wrap;
    assign os_clr  = per_clr || apply;

    tick_counter #(.WIDTH(DIV_WIDTH)) u_period_ctr (
        .clk_in (clk_in),
        .rst    (rst),
        .clr    (per_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .en     (per_en),
        .last   (div_q - DIV_WIDTH'(1)),
        .wrap   (per_wrap)
    );

    // Advances once per rx period; restarts from zero whenever a new divisor is applied.
    tick_counter #(.WIDTH(OS_W)) u_os_ctr (
        .clk_in (clk_in),
        .rst    (rst),
        .clr    (os_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .en     (per_wrap),
        .last   (OS_W'(OVERSAMPLE - 1)),
        .wrap   (os_wrap)
    );

    always_comb begin
        // NOTE: every _d signal gets a default up front so no branch can leave it unassigned and infer a latch.
        state_d     = state_q;
        div_d       = div_q;
        pend_d      = pend_q;
        rx_tick_d   = 1'b0;
        tx_tick_d   = 1'b0;
        locked_d    = locked_q;
        cfg_ready_d = cfg_ready_q;

        case (state_q)
            STOP: begin
                locked_d    = 1'b0;
                cfg_ready_d = 1'b1;
                if (xfer) div_d = clamp_div(cfg_div);
                if (enable) state_d = RUN;
            end
            RUN, PEND: begin
                if (!enable) begin
                    state_d     = STOP;
                    locked_d    = 1'b0;
                    cfg_ready_d = 1'b1;
                    if (state_q == PEND) div_d = pend_q;
                    else if (xfer)       div_d = clamp_div(cfg_div);
                end else begin
                    rx_tick_d = per_wrap;
                    tx_tick_d = os_wrap;
                    if (per_wrap) locked_d = 1'b1;
                    // The old period's tick still goes out; lock is re-earned at the new rate.
                    if (apply) begin
                        div_d       = pend_q;
                        locked_d    = 1'b0;
                        cfg_ready_d = 1'b1;
                        state_d     = RUN;
                    end else if ((state_q == RUN) && xfer) begin
                        pend_d      = clamp_div(cfg_div);
                        cfg_ready_d = 1'b0;
                        state_d     = PEND;
                    end
                end
            end
            default: state_d = STOP;
        endcase
    end

    always_ff @(posedge clk_in) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= STOP;
            div_q       <= DIV_WIDTH'(DEFAULT_DIV);
            pend_q      <= DIV_WIDTH'(DEFAULT_DIV);
            rx_tick_q   <= 1'b0;
            tx_tick_q   <= 1'b0;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            pend_q      <= pend_d;
            rx_tick_q   <= rx_tick_d;
            tx_tick_q   <= tx_tick_d;
            locked_q    <= locked_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign rx_tick    = rx_tick_q;
    assign tx_tick    = tx_tick_q;
    assign locked     = locked_q;
    assign active_div = div_q;

endmodule
